// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default widths for the SPI master shift engine
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  localparam int SPI_DIV_W  = 8;
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} spi_state_t;
endpackage

// File: rtl/spi_baud_gen.sv
// spi_baud_gen: SCK half-period counter, tick every div+1 cycles, restarted by clear
module spi_baud_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = cnt == div;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_master_shift_engine.sv
// spi_master_shift_engine: SPI master framer with one-entry tx buffer and SPTEF/SPIF/MODF pulses
// Define SPI_MODF_DETECT_EN to enable mode-fault detection on ss_in_n.
module spi_master_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DIV_W  = SPI_DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spe,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              SPIDR_wr,
  input  logic [DATA_W-1:0] SPIDR_wdata,
  output logic [DATA_W-1:0] SPIDR_rdata,
  output logic              SPTEF,
  output logic              SPIF,
  output logic              MODF,
  input  logic              ss_in_n,
  output logic              sck,
  output logic              mosi,
  output logic              ss_n,
  input  logic              miso
);
  localparam int EW = $clog2(2 * DATA_W);
  spi_state_t state, state_nx;
  logic              buf_full;
  logic [DATA_W-1:0] buf_data, tx, rx, tx_sh, rx_nx;
  logic              cpha_q, lsbfe_q;
  logic [DIV_W-1:0]  div_q;
  logic [EW-1:0]     edge_cnt;
  logic tick, edge_e, lead_e, samp, drv, last, abort_modf, abort, load_idle, fin, load;
`ifdef SPI_MODF_DETECT_EN
  logic [1:0] ss_sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) ss_sync <= 2'b11;
    else ss_sync <= {ss_sync[0], ss_in_n};
  assign abort_modf = spe && state != IDLE && !ss_sync[1];
`else
  logic unused_ss_in_n;
  assign unused_ss_in_n = ss_in_n;
  assign abort_modf = 1'b0;
`endif
  spi_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .div  (div_q),
    .tick (tick)
  );
  always_comb begin
    last      = edge_cnt == EW'(2 * DATA_W - 1);
    edge_e    = state == SHIFT && tick;
    lead_e    = edge_e && !edge_cnt[0];
    samp      = edge_e && (lead_e ^ cpha_q);
    drv       = edge_e && !samp;
    abort     = (!spe && state != IDLE) || abort_modf;
    load_idle = state == IDLE && spe && buf_full;
    fin       = edge_e && last && !abort;
    load      = load_idle || (fin && buf_full);
    tx_sh     = lsbfe_q ? tx >> 1 : tx << 1;
    rx_nx     = lsbfe_q ? {miso, rx[DATA_W-1:1]} : {rx[DATA_W-2:0], miso};
    state_nx  = state;
    if (abort) state_nx = IDLE;
    else
      case (state)
        IDLE:    state_nx = load_idle ? LEAD : IDLE;
        LEAD:    state_nx = tick ? SHIFT : LEAD;
        SHIFT:   state_nx = fin ? (buf_full ? SHIFT : TRAIL) : SHIFT;
        default: state_nx = tick ? IDLE : TRAIL;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sck         <= 1'b0;
      mosi        <= 1'b0;
      ss_n        <= 1'b1;
      SPIDR_rdata <= '0;
      SPTEF       <= 1'b0;
      SPIF        <= 1'b0;
      MODF        <= 1'b0;
      buf_full    <= 1'b0;
      buf_data    <= '0;
      tx          <= '0;
      rx          <= '0;
      cpha_q      <= 1'b0;
      lsbfe_q     <= 1'b0;
      div_q       <= '0;
      edge_cnt    <= '0;
    end else begin
      SPTEF <= load;
      SPIF  <= fin;
      MODF  <= abort_modf;
      // the final edge is always a trailing edge, which samples only when cpha=1
      if (fin) SPIDR_rdata <= cpha_q ? rx_nx : rx;
      if (abort_modf || load) buf_full <= 1'b0;
      else if (SPIDR_wr && !buf_full) begin
        buf_full <= 1'b1;
        buf_data <= SPIDR_wdata;
      end
      if (abort || (state == IDLE && !load)) begin
        ss_n <= 1'b1;
        sck  <= cpol;
      end else if (load) begin
        ss_n     <= 1'b0;
        sck      <= cpol;
        tx       <= buf_data;
        rx       <= '0;
        cpha_q   <= cpha;
        lsbfe_q  <= lsbfe;
        div_q    <= baud_div;
        edge_cnt <= '0;
        mosi     <= lsbfe ? buf_data[0] : buf_data[DATA_W-1];
      end else if (edge_e) begin
        sck      <= ~sck;
        edge_cnt <= edge_cnt + 1'b1;
        if (samp) rx <= rx_nx;
        // cpha=1 presents the current bit on the leading edge; cpha=0 advances to the next one
        if (drv) begin
          tx   <= tx_sh;
          mosi <= cpha_q ? (lsbfe_q ? tx[0] : tx[DATA_W-1]) : (lsbfe_q ? tx_sh[0] : tx_sh[DATA_W-1]);
        end
      end else if (state == TRAIL && tick) ss_n <= 1'b1;
    end
endmodule

// File: tb/tb_spi_master_shift_engine.sv
// tb_spi_master_shift_engine: scoreboard bench, expected frames queued at write and checked on SPIF
module tb_spi_master_shift_engine;
  logic clk = 0, rst = 1, spe = 0, cpol = 0, cpha = 0, lsbfe = 0;
  logic [7:0] baud_div = 8'd1, SPIDR_wdata = 8'h00;
  logic SPIDR_wr = 0, ss_in_n = 1, loop = 1, miso_val = 0;
  logic [7:0] SPIDR_rdata;
  logic SPTEF, SPIF, MODF, sck, mosi, ss_n, miso;
  assign miso = loop ? mosi : miso_val;
  spi_master_shift_engine dut (
    .clk(clk), .rst(rst), .spe(spe), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .baud_div(baud_div), .SPIDR_wr(SPIDR_wr), .SPIDR_wdata(SPIDR_wdata),
    .SPIDR_rdata(SPIDR_rdata), .SPTEF(SPTEF), .SPIF(SPIF), .MODF(MODF),
    .ss_in_n(ss_in_n), .sck(sck), .mosi(mosi), .ss_n(ss_n), .miso(miso)
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] tx; logic [7:0] rx;} exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int vectors = 0, miscompares = 0, cyc = 0, wr_cyc = 0;
  int sptef_cnt = 0, spif_cnt = 0, modf_cnt = 0, ss_rise_cnt = 0, both_cnt = 0;
  int ssfall_cyc = 0, spif_cyc = 0, sptef_cyc = 0;
  logic sck_p = 0, mosi_p = 0, ss_p = 1;
  logic [7:0] cap = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push_exp(logic [7:0] t, logic [7:0] r);
    exp_t x;
    x.tx = t;
    x.rx = r;
    sb.push_back(x);
  endtask
  task automatic tick_n(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic write_byte(logic [7:0] b);
    SPIDR_wr = 1;
    SPIDR_wdata = b;
    @(posedge clk);
    #1;
    SPIDR_wr = 0;
    wr_cyc = cyc;
  endtask
  task automatic wait_spif(int target);
    int t = 0;
    while (spif_cnt < target && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("spif_count", spif_cnt, target);
  endtask
  task automatic wait_sptef(int target);
    int t = 0;
    while (sptef_cnt < target && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("sptef_count", sptef_cnt, target);
  endtask
  task automatic wait_idle();
    int t = 0;
    while (ss_n !== 1'b1 && t < 500) begin
      @(posedge clk);
      t++;
    end
    tick_n(2);
    check("idle_ss_n", ss_n, 1);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // slave-side view: capture mosi as it stood just before each sampling edge of SCK
  always @(negedge clk) begin
    if (!ss_p && !ss_n && sck != sck_p && ((sck != cpol) ^ cpha))
      cap = lsbfe ? {mosi_p, cap[7:1]} : {cap[6:0], mosi_p};
    if (SPIF === 1'b1) begin
      spif_cnt++;
      spif_cyc = cyc;
      if (SPTEF === 1'b1) both_cnt++;
      if (sb.size() == 0) check("spif_unexpected", SPIF, 0);
      else begin
        e_mon = sb.pop_front();
        check("rdata", SPIDR_rdata, e_mon.rx);
        check("mosi_frame", cap, e_mon.tx);
      end
      cap = 0;
    end
    if (SPTEF === 1'b1) begin
      sptef_cnt++;
      sptef_cyc = cyc;
    end
    if (MODF === 1'b1) modf_cnt++;
    if (ss_p && !ss_n) ssfall_cyc = cyc;
    if (!ss_p && ss_n) begin
      ss_rise_cnt++;
      cap = 0;
    end
    sck_p = sck;
    mosi_p = mosi;
    ss_p = ss_n;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int s, sp, sr, sb2, m;
    tick_n(3);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ss_n", ss_n, 1);
    check("rst_rdata", SPIDR_rdata, 0);
    check("rst_pulses", {SPTEF, SPIF, MODF}, 0);
    rst = 0;
    tick_n(2);
    spe = 1;
    push_exp(8'hA5, 8'hA5);
    write_byte(8'hA5);
    wait_spif(1);
    check("ss_fall_lat", ssfall_cyc - wr_cyc, 1);
    check("sptef_lat", sptef_cyc - wr_cyc, 1);
    check("spif_lat", spif_cyc - ssfall_cyc, 34);
    check("sptef_total", sptef_cnt, 1);
    wait_idle();
    check("sck_idle0", sck, 0);
    cpol = 1; cpha = 1; lsbfe = 1; loop = 0; miso_val = 1;
    tick_n(3);
    check("sck_idle1", sck, 1);
    push_exp(8'h3C, 8'hFF);
    write_byte(8'h3C);
    wait_spif(2);
    wait_idle();
    check("sck_idle1_after", sck, 1);
    cpol = 0; cpha = 0; lsbfe = 0; loop = 1; baud_div = 8'd2;
    tick_n(2);
    sp = sptef_cnt; sr = ss_rise_cnt; sb2 = both_cnt;
    push_exp(8'h11, 8'h11);
    push_exp(8'h22, 8'h22);
    write_byte(8'h11);
    wait_sptef(sp + 1);
    write_byte(8'h22);
    write_byte(8'h33);
    wait_spif(4);
    wait_idle();
    tick_n(60);
    check("b2b_spif", spif_cnt, 4);
    check("b2b_sptef", sptef_cnt, sp + 2);
    check("b2b_ss_rise", ss_rise_cnt, sr + 1);
    check("b2b_same_cycle", both_cnt, sb2 + 1);
    check("b2b_sb_empty", sb.size(), 0);
    baud_div = 8'd1;
    s = spif_cnt;
    sp = sptef_cnt;
    write_byte(8'h5A);
    wait_sptef(sp + 1);
    write_byte(8'h66);
    tick_n(8);
    spe = 0;
    tick_n(3);
    check("spe_abort_ss_n", ss_n, 1);
    check("spe_abort_sck", sck, 0);
    check("spe_abort_no_spif", spif_cnt, s);
    push_exp(8'h66, 8'h66);
    spe = 1;
    wait_spif(s + 1);
    wait_idle();
`ifdef SPI_MODF_DETECT_EN
    s = spif_cnt;
    m = modf_cnt;
    sp = sptef_cnt;
    write_byte(8'h77);
    wait_sptef(sp + 1);
    write_byte(8'h88);
    tick_n(8);
    ss_in_n = 0;
    for (int t = 0; t < 20 && modf_cnt == m; t++) tick_n(1);
    check("modf_pulse", modf_cnt, m + 1);
    check("modf_ss_n", ss_n, 1);
    ss_in_n = 1;
    tick_n(60);
    check("modf_no_spif", spif_cnt, s);
    check("modf_once", modf_cnt, m + 1);
    check("modf_flushed", sptef_cnt, sp + 1);
`else
    s = spif_cnt;
    push_exp(8'h77, 8'h77);
    write_byte(8'h77);
    tick_n(12);
    ss_in_n = 0;
    wait_spif(s + 1);
    check("modf_off", modf_cnt, 0);
    ss_in_n = 1;
    wait_idle();
`endif
    s = spif_cnt;
    write_byte(8'h99);
    tick_n(10);
    rst = 1;
    #2;
    check("rst_mid_ss_n", ss_n, 1);
    check("rst_mid_sck", sck, 0);
    check("rst_mid_mosi", mosi, 0);
    check("rst_mid_rdata", SPIDR_rdata, 0);
    check("rst_mid_pulses", {SPTEF, SPIF, MODF}, 0);
    tick_n(2);
    rst = 0;
    sp = sptef_cnt;
    tick_n(60);
    check("rst_no_spif", spif_cnt, s);
    check("rst_buf_empty", sptef_cnt, sp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
